helppll_loopctrl: RTL and testbench

- Loop controller for the helper-clock frequency-measurement datapath, in the reference clock domain.
- Configures the measurement window (refcntsamp) and consumes each signed freqdiff/stb_freqdiff result.
- Drives a saturating tuning word to the helper oscillator DAC through a coarse (proportional) phase, then a fine (PI) phase.
- Declares and supervises lock, with loss-of-lock fallback to coarse.

---
 rtl/helppll_loopctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_helppll_loopctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/helppll_loopctrl.sv
`default_nettype none
// ============================================================================
// Module   : helppll_loopctrl
// Purpose  : Loop controller for the helper-clock frequency measurement path.
//            Runs in the reference clock domain. It programs the measurement
//            window, consumes each signed frequency-error result and steers a
//            saturating DAC tuning word: first a proportional-only coarse
//            phase, then a PI fine phase. It declares lock and falls back to
//            coarse acquisition when lock is lost.
// Ports    : clk, reset (async, active-high), enable
//            win_coarse / win_fine : window lengths (clk cycles)
//            kp_shift / ki_shift   : gains 2^-shift
//            lock_thresh, lock_cnt : lock criterion
//            freqdiff, stb_freqdiff: signed error (helper - ref) + valid
//            refcntsamp            : window length to the measurement block
//            dac, stb_dac          : tuning word + one-cycle update pulse
//            locked, lost_lock     : lock level + one-cycle loss pulse
//            state                 : 0 IDLE, 1 COARSE, 2 FINE, 3 LOCK
// Revision : 1.0 - initial release
// ============================================================================
module helppll_loopctrl #(
  parameter int DWIDTH   = 32,
  parameter int DACWIDTH = 16,
  parameter int DAC_INIT = 32768,
  parameter int SETTLE   = 2,
  parameter int IWIDTH   = 40
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [DWIDTH-1:0]   win_coarse,
  input  logic [DWIDTH-1:0]   win_fine,
  input  logic [4:0]          kp_shift,
  input  logic [4:0]          ki_shift,
  input  logic [15:0]         lock_thresh,
  input  logic [7:0]          lock_cnt,
  input  logic [DWIDTH-1:0]   freqdiff,
  input  logic                stb_freqdiff,
  output logic [DWIDTH-1:0]   refcntsamp,
  output logic [DACWIDTH-1:0] dac,
  output logic                stb_dac,
  output logic                locked,
  output logic                lost_lock,
  output logic [1:0]          state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_COARSE = 2'd1;
  localparam logic [1:0] S_FINE   = 2'd2;
  localparam logic [1:0] S_LOCK   = 2'd3;

  // Arithmetic width: wide enough for dac +/- a full-scale error, and for the
  // integrator term when IWIDTH exceeds that.
  localparam int AW    = DWIDTH + DACWIDTH + 2;
  localparam int XW    = (IWIDTH + 2 > AW) ? IWIDTH + 2 : AW;
  localparam int CW    = DWIDTH + 2;
  localparam int DISCW = $clog2(SETTLE + 2);

  localparam logic [DISCW-1:0]        DISC_LOAD = DISCW'(SETTLE);
  localparam logic [DACWIDTH-1:0]     DAC_RST   = DACWIDTH'(DAC_INIT);
  localparam logic signed [IWIDTH+1:0] I_MAX    = {3'b000, {(IWIDTH-1){1'b1}}};
  localparam logic signed [IWIDTH+1:0] I_MIN    = {3'b111, {(IWIDTH-1){1'b0}}};

  logic [1:0]               state_q, state_d;
  logic [DWIDTH-1:0]        refcntsamp_q, refcntsamp_d;
  logic [DACWIDTH-1:0]      dac_q, dac_d;
  logic [DACWIDTH-1:0]      base_q, base_d;
  logic                     stb_dac_q, stb_dac_d;
  logic                     locked_q, locked_d;
  logic                     lost_lock_q, lost_lock_d;
  logic signed [IWIDTH-1:0] integ_q, integ_d;
  logic [DISCW-1:0]         disc_q, disc_d;
  logic [7:0]               match_q, match_d;

  // Clamp a wide signed value into the unsigned DAC range.
  function automatic logic [DACWIDTH-1:0] clamp_dac(input logic signed [XW-1:0] v);
    if (v[XW-1])
      clamp_dac = '0;
    else if (|v[XW-2:DACWIDTH])
      clamp_dac = '1;
    else
      clamp_dac = v[DACWIDTH-1:0];
  endfunction

  // ---------------------------------------------------------------- error terms
  logic [DWIDTH-1:0]        abs_e;
  logic [CW-1:0]            abs_x, thr_x;
  logic                     in_thr, over4, valid, disc_busy;
  logic signed [XW-1:0]     e_x;

  always_comb begin
    abs_e = freqdiff;
    // Most-negative input has no positive twin; saturate to the max positive.
    if (freqdiff == {1'b1, {(DWIDTH-1){1'b0}}})
      abs_e = {1'b0, {(DWIDTH-1){1'b1}}};
    else if (freqdiff[DWIDTH-1])
      abs_e = ~freqdiff + DWIDTH'(1);
  end

  assign abs_x     = CW'(abs_e);
  assign thr_x     = CW'(lock_thresh);
  assign in_thr    = (abs_x <= thr_x);
  assign over4     = (abs_x > (thr_x << 2));
  assign e_x       = {{(XW-DWIDTH){freqdiff[DWIDTH-1]}}, freqdiff};
  assign disc_busy = (disc_q != '0);
  assign valid     = stb_freqdiff && !disc_busy;

  // ---------------------------------------------------------------- integrator
  logic signed [IWIDTH+1:0] i_sum;
  logic signed [IWIDTH-1:0] integ_new;
  logic signed [XW-1:0]     integ_x;

  assign i_sum = {{2{integ_q[IWIDTH-1]}}, integ_q}
               + {{(IWIDTH+2-DWIDTH){freqdiff[DWIDTH-1]}}, freqdiff};

  always_comb begin
    if (i_sum > I_MAX)
      integ_new = I_MAX[IWIDTH-1:0];
    else if (i_sum < I_MIN)
      integ_new = I_MIN[IWIDTH-1:0];
    else
      integ_new = i_sum[IWIDTH-1:0];
  end

  assign integ_x = {{(XW-IWIDTH){integ_new[IWIDTH-1]}}, integ_new};

  // ---------------------------------------------------------------- dac targets
  logic signed [XW-1:0] p_term, i_term, dac_x, base_x, coarse_t, fine_t;
  logic [DACWIDTH-1:0]  coarse_dac, fine_dac;

  assign p_term     = e_x >>> kp_shift;
  assign i_term     = integ_x >>> ki_shift;
  assign dac_x      = {{(XW-DACWIDTH){1'b0}}, dac_q};
  assign base_x     = {{(XW-DACWIDTH){1'b0}}, base_q};
  // Positive error means the helper runs fast, so the tuning word decreases.
  assign coarse_t   = dac_x - p_term;
  assign fine_t     = base_x - p_term - i_term;
  assign coarse_dac = clamp_dac(coarse_t);
  assign fine_dac   = clamp_dac(fine_t);

  // ---------------------------------------------------------------- lock count
  logic [7:0] match_next, lock_target;
  logic       lock_hit;

  assign match_next  = !in_thr ? 8'd0 : ((match_q == 8'hFF) ? 8'hFF : match_q + 8'd1);
  assign lock_target = (lock_cnt == 8'd0) ? 8'd1 : lock_cnt;
  assign lock_hit    = (match_next >= lock_target);

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   state_d = S_COARSE;
        S_COARSE: if (valid && in_thr)   state_d = S_FINE;
        S_FINE:   if (valid && lock_hit) state_d = S_LOCK;
        S_LOCK:   if (valid && over4)    state_d = S_COARSE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM: outputs / datapath
  always_comb begin
    refcntsamp_d = refcntsamp_q;
    dac_d        = dac_q;
    base_d       = base_q;
    stb_dac_d    = 1'b0;
    locked_d     = locked_q;
    lost_lock_d  = 1'b0;
    integ_d      = integ_q;
    disc_d       = disc_q;
    match_d      = match_q;

    if (!enable) begin
      // Abort wins over any coincident strobe; dac keeps its value.
      locked_d     = 1'b0;
      integ_d      = '0;
      match_d      = 8'd0;
      refcntsamp_d = win_coarse;
      disc_d       = DISC_LOAD;
    end else if (state_q == S_IDLE) begin
      refcntsamp_d = win_coarse;
      disc_d       = DISC_LOAD;
    end else if (stb_freqdiff && disc_busy) begin
      // Result still measured with the previous window: drop it.
      disc_d = disc_q - DISCW'(1);
    end else if (valid) begin
      case (state_q)
        S_COARSE: begin
          dac_d     = coarse_dac;
          stb_dac_d = 1'b1;
          if (in_thr) begin
            refcntsamp_d = win_fine;
            disc_d       = DISC_LOAD;
            integ_d      = '0;
            base_d       = coarse_dac;
            match_d      = 8'd0;
          end
        end
        S_FINE: begin
          integ_d   = integ_new;
          dac_d     = fine_dac;
          stb_dac_d = 1'b1;
          match_d   = match_next;
          if (lock_hit)
            locked_d = 1'b1;
        end
        S_LOCK: begin
          if (over4) begin
            lost_lock_d  = 1'b1;
            locked_d     = 1'b0;
            refcntsamp_d = win_coarse;
            disc_d       = DISC_LOAD;
          end else begin
            integ_d   = integ_new;
            dac_d     = fine_dac;
            stb_dac_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refcntsamp_q <= '0;
      dac_q        <= DAC_RST;
      base_q       <= DAC_RST;
      stb_dac_q    <= 1'b0;
      locked_q     <= 1'b0;
      lost_lock_q  <= 1'b0;
      integ_q      <= '0;
      disc_q       <= DISC_LOAD;
      match_q      <= 8'd0;
    end else begin
      refcntsamp_q <= refcntsamp_d;
      dac_q        <= dac_d;
      base_q       <= base_d;
      stb_dac_q    <= stb_dac_d;
      locked_q     <= locked_d;
      lost_lock_q  <= lost_lock_d;
      integ_q      <= integ_d;
      disc_q       <= disc_d;
      match_q      <= match_d;
    end
  end

  assign refcntsamp = refcntsamp_q;
  assign dac        = dac_q;
  assign stb_dac    = stb_dac_q;
  assign locked     = locked_q;
  assign lost_lock  = lost_lock_q;
  assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_helppll_loopctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_helppll_loopctrl
// Purpose  : Self-checking bench for helppll_loopctrl: directed vector table,
//            hand-written reset sequence and randomized traffic compared
//            against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_helppll_loopctrl;

  localparam int DW       = 32;
  localparam int DACW     = 16;
  localparam int DAC_INIT = 32768;
  localparam int SETTLE   = 2;
  localparam int IW       = 40;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [DW-1:0]   win_coarse, win_fine, freqdiff;
  logic [4:0]      kp_shift, ki_shift;
  logic [15:0]     lock_thresh;
  logic [7:0]      lock_cnt;
  logic            stb_freqdiff;
  logic [DW-1:0]   refcntsamp;
  logic [DACW-1:0] dac;
  logic            stb_dac, locked, lost_lock;
  logic [1:0]      state;

  int n_cmp  = 0;
  int n_fail = 0;

  helppll_loopctrl #(
    .DWIDTH(DW), .DACWIDTH(DACW), .DAC_INIT(DAC_INIT), .SETTLE(SETTLE), .IWIDTH(IW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .win_coarse(win_coarse), .win_fine(win_fine),
    .kp_shift(kp_shift), .ki_shift(ki_shift),
    .lock_thresh(lock_thresh), .lock_cnt(lock_cnt),
    .freqdiff(freqdiff), .stb_freqdiff(stb_freqdiff),
    .refcntsamp(refcntsamp), .dac(dac), .stb_dac(stb_dac),
    .locked(locked), .lost_lock(lost_lock), .state(state)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- reference model
  // Mode numbers follow the state output encoding.
  int     m_mode, m_disc, m_match;
  longint m_dac, m_base, m_integ, m_ref;
  bit     m_stb, m_locked, m_lost;

  function automatic longint clampd(input longint v);
    longint hi;
    hi = (longint'(1) <<< DACW) - 1;
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_disc = SETTLE; m_match = 0;
    m_dac = DAC_INIT; m_base = DAC_INIT; m_integ = 0; m_ref = 0;
    m_stb = 0; m_locked = 0; m_lost = 0;
  endtask

  // Advance the model by one clock using the inputs presented at this edge.
  task automatic model_clock();
    longint e, ae, lim, need;
    m_stb  = 0;
    m_lost = 0;
    e  = longint'($signed(freqdiff));
    ae = (e < 0) ? -e : e;
    if (ae > 64'd2147483647) ae = 64'd2147483647;
    lim  = longint'(1) <<< (IW - 1);
    need = (lock_cnt == 0) ? 1 : longint'(lock_cnt);
    if (!enable) begin
      m_mode = 0; m_locked = 0; m_integ = 0; m_match = 0;
      m_ref = longint'(win_coarse); m_disc = SETTLE;
    end else if (m_mode == 0) begin
      m_mode = 1; m_ref = longint'(win_coarse); m_disc = SETTLE;
    end else if (stb_freqdiff) begin
      if (m_disc > 0) begin
        m_disc--;
      end else if (m_mode == 1) begin
        m_dac = clampd(m_dac - (e >>> kp_shift));
        m_stb = 1;
        if (ae <= longint'(lock_thresh)) begin
          m_mode = 2; m_ref = longint'(win_fine); m_disc = SETTLE;
          m_integ = 0; m_base = m_dac; m_match = 0;
        end
      end else if (m_mode == 3 && ae > 4 * longint'(lock_thresh)) begin
        m_lost = 1; m_locked = 0; m_mode = 1;
        m_ref = longint'(win_coarse); m_disc = SETTLE;
      end else begin
        m_integ = m_integ + e;
        if (m_integ > lim - 1) m_integ = lim - 1;
        if (m_integ < -lim)    m_integ = -lim;
        m_dac = clampd(m_base - (e >>> kp_shift) - (m_integ >>> ki_shift));
        m_stb = 1;
        if (m_mode == 2) begin
          m_match = (ae <= longint'(lock_thresh)) ? m_match + 1 : 0;
          if (m_match >= need) begin
            m_mode = 3; m_locked = 1;
          end
        end
      end
    end
  endtask

  // ---------------------------------------------------------------- checking
  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    chk("model.state",     longint'(state),      longint'(m_mode));
    chk("model.dac",       longint'(dac),        m_dac);
    chk("model.stb_dac",   longint'(stb_dac),    longint'(m_stb));
    chk("model.locked",    longint'(locked),     longint'(m_locked));
    chk("model.lost_lock", longint'(lost_lock),  longint'(m_lost));
    chk("model.refcnt",    longint'(refcntsamp), m_ref);
  endtask

  // One clock: inputs already driven, model follows the edge, outputs sampled 1ns later.
  task automatic cycle();
    @(posedge clk);
    model_clock();
    #1;
    check_model();
  endtask

  // ---------------------------------------------------------------- vector table
  typedef struct {
    bit en; bit stb; int fd; int kp; int ki;
    int x_state; int x_dac; bit x_stb; bit x_locked; bit x_lost; int x_ref;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit en, input bit stb, input int fd, input int kp,
                              input int ki, input int xs, input int xd, input bit xstb,
                              input bit xl, input bit xlost, input int xr);
    vec_t v;
    v.en = en; v.stb = stb; v.fd = fd; v.kp = kp; v.ki = ki;
    v.x_state = xs; v.x_dac = xd; v.x_stb = xstb;
    v.x_locked = xl; v.x_lost = xlost; v.x_ref = xr;
    return v;
  endfunction

  initial begin
    // Disabled: strobes ignored, window programmed to win_coarse.
    tbl.push_back(mk(0, 1,  400, 2, 0, 0, 32768, 0, 0, 0, 1000));
    tbl.push_back(mk(1, 0,    0, 2, 0, 1, 32768, 0, 0, 0, 1000));
    // COARSE: two discards, then proportional steps of 400>>>2 = 100.
    tbl.push_back(mk(1, 1,  400, 2, 0, 1, 32768, 0, 0, 0, 1000));
    tbl.push_back(mk(1, 1,  400, 2, 0, 1, 32768, 0, 0, 0, 1000));
    tbl.push_back(mk(1, 1,  400, 2, 0, 1, 32668, 1, 0, 0, 1000));
    tbl.push_back(mk(1, 0,    0, 2, 0, 1, 32668, 0, 0, 0, 1000));
    tbl.push_back(mk(1, 1,  400, 2, 0, 1, 32568, 1, 0, 0, 1000));
    tbl.push_back(mk(1, 1,  400, 2, 0, 1, 32468, 1, 0, 0, 1000));
    tbl.push_back(mk(1, 1,  400, 2, 0, 1, 32368, 1, 0, 0, 1000));
    tbl.push_back(mk(1, 0,    0, 2, 0, 1, 32368, 0, 0, 0, 1000));
    // In-threshold error -5: dac +2, enter FINE with win_fine.
    tbl.push_back(mk(1, 1,   -5, 2, 0, 2, 32370, 1, 0, 0, 16000));
    // FINE, kp=ki=0, base 32370: two discards then PI updates.
    tbl.push_back(mk(1, 1,    7, 0, 0, 2, 32370, 0, 0, 0, 16000));
    tbl.push_back(mk(1, 1,    7, 0, 0, 2, 32370, 0, 0, 0, 16000));
    tbl.push_back(mk(1, 1,    3, 0, 0, 2, 32364, 1, 0, 0, 16000));
    tbl.push_back(mk(1, 1,   20, 0, 0, 2, 32327, 1, 0, 0, 16000));
    tbl.push_back(mk(1, 1,    1, 0, 0, 2, 32345, 1, 0, 0, 16000));
    tbl.push_back(mk(1, 1,    2, 0, 0, 2, 32342, 1, 0, 0, 16000));
    tbl.push_back(mk(1, 1,    0, 0, 0, 3, 32344, 1, 1, 0, 16000));
    tbl.push_back(mk(1, 0,    0, 0, 0, 3, 32344, 0, 1, 0, 16000));
    // LOCK: |33| > 4*8 -> loss of lock, dac frozen, back to COARSE.
    tbl.push_back(mk(1, 1,   33, 0, 0, 1, 32344, 0, 0, 1, 1000));
    tbl.push_back(mk(1, 0,    0, 0, 0, 1, 32344, 0, 0, 0, 1000));
    tbl.push_back(mk(1, 1,  100, 0, 0, 1, 32344, 0, 0, 0, 1000));
    tbl.push_back(mk(1, 1,  100, 0, 0, 1, 32344, 0, 0, 0, 1000));
    // Saturation: drive dac to 10, then clamp low and high.
    tbl.push_back(mk(1, 1, 32334, 0, 0, 1,    10, 1, 0, 0, 1000));
    tbl.push_back(mk(1, 1,  100, 0, 0, 1,     0, 1, 0, 0, 1000));
    tbl.push_back(mk(1, 1, 32'sh80000000, 0, 0, 1, 65535, 1, 0, 0, 1000));
    // Enable drop coincident with a strobe: IDLE, no stb_dac, dac held.
    tbl.push_back(mk(0, 1,    3, 0, 0, 0, 65535, 0, 0, 0, 1000));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, 65535, 0, 0, 0, 1000));
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    reset = 1'b1; enable = 1'b0; stb_freqdiff = 1'b0; freqdiff = '0;
    win_coarse = 32'd1000; win_fine = 32'd16000;
    kp_shift = 5'd2; ki_shift = 5'd0; lock_thresh = 16'd8; lock_cnt = 8'd3;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("rst.state",   longint'(state),      0);
    chk("rst.dac",     longint'(dac),        DAC_INIT);
    chk("rst.refcnt",  longint'(refcntsamp), 0);
    chk("rst.stb_dac", longint'(stb_dac),    0);
    chk("rst.locked",  longint'(locked),     0);
    reset = 1'b0;

    // Directed table.
    foreach (tbl[i]) begin
      enable = tbl[i].en; stb_freqdiff = tbl[i].stb; freqdiff = tbl[i].fd;
      kp_shift = 5'(tbl[i].kp); ki_shift = 5'(tbl[i].ki);
      cycle();
      chk($sformatf("vec%0d.state", i),  longint'(state),      tbl[i].x_state);
      chk($sformatf("vec%0d.dac", i),    longint'(dac),        tbl[i].x_dac);
      chk($sformatf("vec%0d.stb", i),    longint'(stb_dac),    longint'(tbl[i].x_stb));
      chk($sformatf("vec%0d.locked", i), longint'(locked),     longint'(tbl[i].x_locked));
      chk($sformatf("vec%0d.lost", i),   longint'(lost_lock),  longint'(tbl[i].x_lost));
      chk($sformatf("vec%0d.ref", i),    longint'(refcntsamp), tbl[i].x_ref);
    end

    // Reset asserted asynchronously while in FINE.
    enable = 1'b1; stb_freqdiff = 1'b0; freqdiff = '0;
    cycle();
    stb_freqdiff = 1'b1;
    repeat (3) cycle();
    stb_freqdiff = 1'b0;
    cycle();
    chk("midfine.state", longint'(state), 2);
    reset = 1'b1;
    #1;
    model_reset();
    chk("arst.state",   longint'(state),      0);
    chk("arst.dac",     longint'(dac),        DAC_INIT);
    chk("arst.refcnt",  longint'(refcntsamp), 0);
    chk("arst.stb_dac", longint'(stb_dac),    0);
    chk("arst.locked",  longint'(locked),     0);
    chk("arst.lost",    longint'(lost_lock),  0);
    #2;
    reset = 1'b0;

    // Randomized traffic against the reference model.
    for (int c = 0; c < 4000; c++) begin
      int r;
      if (c % 250 == 0) begin
        kp_shift    = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 4));
        ki_shift    = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 6));
        lock_thresh = 16'($urandom_range(4, 20));
        lock_cnt    = 8'($urandom_range(0, 3));
        win_coarse  = 32'($urandom_range(100, 5000));
        win_fine    = 32'($urandom_range(5001, 60000));
      end
      enable       = ($urandom_range(0, 149) != 0);
      stb_freqdiff = ($urandom_range(0, 99) < 40);
      r = $urandom_range(0, 99);
      if (r < 80)      freqdiff = 32'($signed($urandom_range(0, 24)) - 12);
      else if (r < 95) freqdiff = 32'($signed($urandom_range(0, 400)) - 200);
      else             freqdiff = $urandom();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
